// File: rtl/ctrl_mc_pkg.sv
// Shared types and instruction-field layout for the multi-channel program controller.
package ctrl_mc_pkg;

  typedef enum logic [3:0] {
    StInit,
    StPcRst,
    StWait,
    StFetch,
    StDecode,
    StRegwi,
    StSet,
    StBranch,
    StErr,
    StEnd
  } state_t;

  localparam logic [7:0] OP_REGWI = 8'h19;
  localparam logic [7:0] OP_SET   = 8'h51;
  localparam logic [7:0] OP_SETB  = 8'h58;
  localparam logic [7:0] OP_JUMP  = 8'h60;
  localparam logic [7:0] OP_DJNZ  = 8'h61;
  localparam logic [7:0] OP_END   = 8'h3F;

  localparam int unsigned OPC_LSB = 56;
  localparam int unsigned HDR_LSB = 35;  // {opcode,page,oper} = ir[63:35]
  localparam int unsigned CH_LSB  = 50;
  localparam int unsigned WA_LSB  = 41;
  localparam int unsigned RA0_MSB = 34;
  localparam int unsigned NRD     = 7;

endpackage

// File: rtl/ctrl_mc_regfile.sv
// 32-entry register file: seven combinational read ports, one synchronous write port.
module ctrl_mc_regfile #(
  parameter int unsigned B = 32
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           we,
  input  logic [4:0]     waddr,
  input  logic [B-1:0]   wdata,
  input  logic [34:0]    raddr,
  output logic [7*B-1:0] rdata
);

  logic [B-1:0] regs_q [32];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    for (int p = 0; p < 7; p++) rdata[p*B +: B] = regs_q[raddr[p*5 +: 5]];
  end

endmodule

// File: rtl/synchronizer_n.sv
// N-stage flop synchronizer for a single asynchronous level input.
module synchronizer_n #(
  parameter int unsigned N = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic dout
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= {sync_q[N-2:0], din};
  end

  assign dout = sync_q[N-1];

endmodule

// File: rtl/ctrl_mc.sv
// Program controller: fetches 64-bit instructions, keeps a register file and
// dispatches SET/SETB command words to one of NCH downstream FIFOs.
module ctrl_mc
  import ctrl_mc_pkg::*;
#(
  parameter int unsigned PMEM_N = 10,
  parameter int unsigned B      = 32,
  parameter int unsigned NCH    = 4,
  parameter int unsigned FW     = 29 + 7 * B
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [PMEM_N-1:0] pmem_addr,
  input  logic [63:0]       pmem_do,
  input  logic              START_REG,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [31:0]       inst_cnt,
  output logic [NCH-1:0]    fifo_wr_en,
  output logic [FW-1:0]     fifo_din,
  input  logic [NCH-1:0]    fifo_ready
);

  localparam int unsigned PW = PMEM_N - 3;

  if (FW != 29 + 7 * B) begin : g_fw_check
    $error("ctrl_mc: FW must equal 29+7*B");
  end

  state_t          state_q, state_d;
  logic [PW-1:0]   pc_q, pc_d;
  logic [63:0]     ir_q, ir_d;
  logic            err_q, err_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            run;
  logic            rf_we;
  logic [B-1:0]    rf_wdata;
  logic [34:0]     raddr;
  logic [7*B-1:0]  rdata;
  logic [7:0]      opcode;
  logic [2:0]      ch;
  logic [4:0]      wa;
  logic            ch_ok;
  logic [B-1:0]    djnz_val;

  synchronizer_n #(.N(2)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .din  (START_REG),
    .dout (run)
  );

  assign opcode   = ir_q[OPC_LSB +: 8];
  assign ch       = ir_q[CH_LSB +: 3];
  assign wa       = ir_q[WA_LSB +: 5];
  assign ch_ok    = 32'(ch) < NCH;
  assign djnz_val = rdata[B-1:0] - B'(1);

  // Read port 0 doubles as the DJNZ counter read while in BRANCH.
  always_comb begin
    raddr = '0;
    for (int p = 0; p < 7; p++) raddr[p*5 +: 5] = ir_q[RA0_MSB - 5*p -: 5];
    if (state_q == StBranch) raddr[4:0] = wa;
  end

  ctrl_mc_regfile #(.B(B)) u_regfile (
    .clk   (clk),
    .rstn  (rstn),
    .we    (rf_we),
    .waddr (wa),
    .wdata (rf_wdata),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_comb begin
    fifo_wr_en = '0;
    for (int i = 0; i < NCH; i++) begin
      fifo_wr_en[i] = (state_q == StSet) && run && (ch == 3'(i)) && fifo_ready[i];
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    rf_we    = 1'b0;
    rf_wdata = ir_q[B-1:0];
    unique case (state_q)
      StInit:  if (run) state_d = StPcRst;
      StPcRst: begin
        pc_d    = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait:  state_d = StFetch;
      StFetch: begin
        ir_d    = pmem_do;
        pc_d    = pc_q + PW'(1);
        state_d = StDecode;
      end
      StDecode: begin
        case (opcode)
          OP_REGWI:        state_d = StRegwi;
          OP_SET, OP_SETB: state_d = ch_ok ? StSet : StErr;
          OP_JUMP, OP_DJNZ: state_d = StBranch;
          OP_END:          state_d = StEnd;
          default:         state_d = StErr;
        endcase
      end
      StRegwi: begin
        rf_we   = 1'b1;
        cnt_d   = cnt_q + 32'd1;
        state_d = StFetch;
      end
      StSet: begin
        if (|fifo_wr_en) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = StFetch;
        end
      end
      StBranch: begin
        if (opcode == OP_DJNZ) begin
          rf_we    = 1'b1;
          rf_wdata = djnz_val;
        end
        if (opcode == OP_JUMP || djnz_val != '0) pc_d = ir_q[PW-1:0];
        cnt_d   = cnt_q + 32'd1;
        state_d = StWait;
      end
      StErr: begin
        err_d   = 1'b1;
        state_d = StEnd;
      end
      StEnd:   if (!run) state_d = StInit;
      default: state_d = StInit;
    endcase
    // Abort drops everything in flight; registers, counters and err keep their values.
    if (!run && state_q != StInit && state_q != StEnd) begin
      state_d = StInit;
      pc_d    = pc_q;
      ir_d    = ir_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      rf_we   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StInit;
      pc_q    <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pmem_addr = {pc_q, 3'b000};
  assign start     = state_q == StPcRst;
  assign busy      = state_q != StInit && state_q != StEnd;
  assign done      = state_q == StEnd;
  assign err       = err_q;
  assign inst_cnt  = cnt_q;
  assign fifo_din  = {ir_q[63:HDR_LSB], rdata};

endmodule
